// File: rtl/rvs192_wb_pkg.sv
// Shared types and helpers for the RVS192 write-back buffer.
// The entry struct describes the default configuration: 32-bit addresses, 64-byte blocks.
package rvs192_wb_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_BLOCK_BYTES = 64;
  localparam int DEF_OFF_W       = $clog2(DEF_BLOCK_BYTES);
  localparam int DEF_BA_W        = DEF_ADDR_W - DEF_OFF_W;
  localparam int DEF_DATA_W      = 8 * DEF_BLOCK_BYTES;

  typedef struct packed {
    logic                  valid;
    logic [DEF_BA_W-1:0]   baddr;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

  // The buffer depth need not be a power of two, so a pointer cannot rely on
  // binary overflow to wrap. It returns to 0 after the last entry.
  function automatic int unsigned wb_ptr_inc(input int unsigned ptr,
                                             input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rvs192_wb_cam.sv
// Address comparator across all entries.
// Ties resolve to the youngest matching entry.
module rvs192_wb_cam #(
  parameter int unsigned DEPTH = 10,
  parameter int unsigned BA_W  = 26,
  parameter int unsigned PTR_W = 4
) (
  input  logic [DEPTH-1:0]           valid,
  input  logic [DEPTH-1:0][BA_W-1:0] baddr,
  input  logic [PTR_W-1:0]           head,
  input  logic                       skip_head,
  input  logic [BA_W-1:0]            key,
  output logic                       hit,
  output logic [PTR_W-1:0]           idx
);

  // Walk from the oldest entry to the youngest. A later match overrides an
  // earlier one, so the youngest match wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      logic [PTR_W:0]   sum;
      logic [PTR_W-1:0] pos;
      sum = {1'b0, head} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(DEPTH)) sum = sum - (PTR_W+1)'(DEPTH);
      pos = sum[PTR_W-1:0];
      if (!(skip_head && k == 0) && valid[pos] && baddr[pos] == key) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/rvs192_wb_buffer.sv
// Write-back buffer: a FIFO of evicted dirty blocks that drains to the next memory level.
// It merges re-evictions into queued entries and serves lookups for misses.
module rvs192_wb_buffer
  import rvs192_wb_pkg::*;
#(
  parameter  int unsigned DEPTH       = 10,
  parameter  int unsigned BLOCK_BYTES = 64,
  parameter  int unsigned ADDR_W      = 32,
  localparam int unsigned OFF_W       = $clog2(BLOCK_BYTES),
  localparam int unsigned BA_W        = ADDR_W - OFF_W,
  localparam int unsigned DATA_W      = 8 * BLOCK_BYTES,
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enq_valid_i,
  output logic              enq_ready_o,
  input  logic [BA_W-1:0]   enq_baddr_i,
  input  logic [DATA_W-1:0] enq_data_i,
  output logic              deq_valid_o,
  input  logic              deq_ready_i,
  output logic [BA_W-1:0]   deq_baddr_o,
  output logic [DATA_W-1:0] deq_data_o,
  input  logic [BA_W-1:0]   lk_baddr_i,
  output logic              lk_hit_o,
  output logic [DATA_W-1:0] lk_data_o,
  input  logic              flush_i,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0][BA_W-1:0]   baddr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [PTR_W-1:0]             head_q, tail_q;
  logic [CNT_W-1:0]             count_q;

  logic             full, empty;
  logic             enq_fire, deq_fire, enq_alloc, enq_merge;
  logic             merge_hit;
  logic [PTR_W-1:0] merge_idx, lk_idx;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Holding ready low during reset keeps the cache from handing over a block
  // that would be lost.
  assign enq_ready_o = rst_n & ~full & ~flush_i;
  assign enq_fire    = enq_valid_i & enq_ready_o;
  assign deq_valid_o = ~empty;
  assign deq_fire    = deq_valid_o & deq_ready_i;
  assign deq_baddr_o = baddr_q[head_q];
  assign deq_data_o  = data_q[head_q];
  assign empty_o     = empty;
  assign count_o     = count_q;

  // The head entry is excluded from merging so the block already presented to
  // memory cannot change under it.
  rvs192_wb_cam #(.DEPTH(DEPTH), .BA_W(BA_W), .PTR_W(PTR_W)) u_merge_cam (
    .valid     (valid_q),
    .baddr     (baddr_q),
    .head      (head_q),
    .skip_head (1'b1),
    .key       (enq_baddr_i),
    .hit       (merge_hit),
    .idx       (merge_idx)
  );

  rvs192_wb_cam #(.DEPTH(DEPTH), .BA_W(BA_W), .PTR_W(PTR_W)) u_lookup_cam (
    .valid     (valid_q),
    .baddr     (baddr_q),
    .head      (head_q),
    .skip_head (1'b0),
    .key       (lk_baddr_i),
    .hit       (lk_hit_o),
    .idx       (lk_idx)
  );

  assign lk_data_o = lk_hit_o ? data_q[lk_idx] : '0;
  assign enq_merge = enq_fire & merge_hit;
  assign enq_alloc = enq_fire & ~merge_hit;

  // NOTE: sequential state uses non-blocking assignments, so every read in the
  // block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (deq_fire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= PTR_W'(wb_ptr_inc(32'(head_q), DEPTH));
      end
      if (enq_alloc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= PTR_W'(wb_ptr_inc(32'(tail_q), DEPTH));
      end
      count_q <= count_q + CNT_W'(enq_alloc) - CNT_W'(deq_fire);
    end
  end

  // NOTE: the payload arrays have no reset. Valid bits gate every use of them,
  // so clearing the wide data storage would add logic without changing behaviour.
  always_ff @(posedge clk) begin
    if (enq_alloc) begin
      baddr_q[tail_q] <= enq_baddr_i;
      data_q[tail_q]  <= enq_data_i;
    end
    if (enq_merge) begin
      data_q[merge_idx] <= enq_data_i;
    end
  end

endmodule
